mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

- Shares the core's single external memory bus between instruction fetch (IF) and data access (MEM).
- Sequences one transaction at a time on the bus handshake.
- Raises per-stage stall requests into the pipeline Control block.
- Buffers completed results while that stage is stalled, and discards in-flight fetch data after a pipeline flush.

## Interface
- No parameters; address/data width fixed at 32.
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- i_en  in  1  IF fetch request; i_addr held stable while IF stalled
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched word
- i_stallreq  out  1  IF stall request to Control
- if_stall  in  1  IF stall bit from Control
- if_flush  in  1  IF flush bit from Control
- d_en  in  1  MEM access request
- d_wen  in  4  byte write enables; 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_stallreq  out  1  MEM stall request to Control
- mem_stall  in  1  MEM stall bit from Control
- bus_req  out  1  bus request; addr/wr/wstrb/wdata valid while high
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  byte strobes (= d_wen for data, 0 for fetch)
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  address accepted this cycle
- bus_data_ok  in  1  data phase complete; bus_rdata valid
- bus_rdata  in  32  bus read data

## Operation
- State machine states:
  - IDLE: no bus activity.
  - I_REQ, D_REQ: bus_req=1, wait for bus_addr_ok.
  - I_WAIT, D_WAIT: bus_req=0, wait for bus_data_ok.
- A requester is **pending** when its en=1 and its done flag=0.
- IDLE transitions:
  - d pending → D_REQ.
  - else i pending → I_REQ.
  - else stay in IDLE.
- X_REQ → X_WAIT on bus_addr_ok. X_WAIT → IDLE on bus_data_ok.
- At most one outstanding transaction on the bus.
- Stall requests:
  - i_stallreq = i_en & ~i_done & ~(state==I_WAIT & bus_data_ok & ~drop).
  - d_stallreq = d_en & ~d_done & ~(state==D_WAIT & bus_data_ok).
- Read data outputs:
  - On completion, rdata = bus_rdata (pass-through).
  - If that stage's stall input is 1 on the completion cycle, bus_rdata is latched into the stage buffer and done is set.
  - While done=1, rdata = buffer.
- Done flags clear on the first cycle the stage's stall input is 0.
- Writes complete the same way; d_rdata is don't-care for writes.
- Flush:
  - if_flush in I_REQ → abort to IDLE only if bus_addr_ok=0 that cycle.
  - if_flush in I_WAIT, or in I_REQ with bus_addr_ok=1 → set drop.
  - On the dropped data_ok: discard the data, clear drop, go to IDLE. i_rdata is not updated and i_done is not set.
  - if_flush also clears i_done.
  - MEM transactions are never aborted: a store accepted on the bus completes.
- Simultaneous d_en and i_en in IDLE resolve per Configuration.

## Timing
- Reset values:
  - state=IDLE, bus_req=0, bus_wr=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
  - i_done=d_done=drop=0, buffers=0, rr_last=0.
  - Stall requests are combinational, so during reset they follow en.
- Request seen in IDLE at cycle 0:
  - bus_req asserts in cycle 1.
  - If bus_addr_ok arrives in cycle 1, bus_data_ok arrives no earlier than cycle 2.
  - stallreq falls in the bus_data_ok cycle; minimum 3-cycle access, back-to-back accesses every 3 cycles.
- Bus address, strobes and write data are registered at the IDLE→REQ transition. They hold stable until bus_addr_ok.
- bus_data_ok in IDLE or X_REQ is a protocol error and is ignored.
- Reset asserted mid-transaction returns to IDLE immediately. The external bus must be reset together with the arbiter.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined:
  - Round-robin when both are pending in IDLE: the requester not granted last wins.
  - rr_last is updated on each grant; 0 = data granted last.
- Undefined:
  - Fixed priority, data always wins; rr_last is absent.
  - IF may starve while MEM issues consecutive accesses, which is acceptable because MEM stalling freezes IF.

## Test plan
- Single fetch, i_addr=0xBFC00000, bus_addr_ok in cycle 1, bus_data_ok in cycle 2 with bus_rdata=0x24080001 → i_stallreq high for cycles 0-1 and low in cycle 2; i_rdata=0x24080001.
- Simultaneous i_en and d_en (d_wen=4'b1111, d_addr=0x80000010, d_wdata=0xDEADBEEF):
  - Undefined macro: store is issued first with bus_wr=1 and bus_wstrb=4'hF, then the fetch.
  - Defined macro with rr_last=0: fetch is issued first.
- Fetch completes with bus_rdata=0x11111111 while if_stall=1 for 3 cycles → no reissue on the bus; i_rdata holds 0x11111111; i_done clears when if_stall drops.
- if_flush in I_WAIT, then bus_data_ok with bus_rdata=0x22222222 → i_rdata unchanged and no completion. The next fetch from the new i_addr issues the following cycle.
- resetn pulsed low during D_WAIT → state IDLE, bus_req=0, all done flags 0; a load re-issues after release.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and data access,
// one transaction at a time. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_en,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stallreq,
  input  logic        if_stall,
  input  logic        if_flush,
  input  logic        d_en,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stallreq,
  input  logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        drop_q, drop_d;
  logic [31:0] i_buf_q, i_buf_d;
  logic [31:0] d_buf_q, d_buf_d;
`ifdef MEM_ARB_RR_EN
  logic        rr_last_q, rr_last_d;
`endif

  logic i_pend, d_pend, i_cmpl, d_cmpl, grant_i, grant_d;

  always_comb begin
    i_pend = i_en & ~i_done_q;
    d_pend = d_en & ~d_done_q;
    // A dropped fetch never counts as a completion.
    i_cmpl = (state_q == I_WAIT) & bus_data_ok & ~drop_q;
    d_cmpl = (state_q == D_WAIT) & bus_data_ok;
`ifdef MEM_ARB_RR_EN
    // rr_last=0 means data was granted last, so fetch wins a tie.
    grant_d = d_pend & (~i_pend | rr_last_q);
`else
    grant_d = d_pend;
`endif
    grant_i = i_pend & ~grant_d;
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_wr_d    = bus_wr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    drop_d      = drop_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_REQ;
          bus_req_d   = 1'b1;
          bus_wr_d    = |d_wen;
          bus_wstrb_d = d_wen;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
          rr_last_d   = 1'b0;
`endif
        end else if (grant_i) begin
          state_d     = I_REQ;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_wstrb_d = 4'h0;
          bus_addr_d  = i_addr;
`ifdef MEM_ARB_RR_EN
          rr_last_d   = 1'b1;
`endif
        end
      end
      I_REQ: begin
        if (bus_addr_ok) begin
          state_d   = I_WAIT;
          bus_req_d = 1'b0;
          if (if_flush) drop_d = 1'b1;
        end else if (if_flush) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      I_WAIT: begin
        // A flush coinciding with data_ok needs no drop: the data is already gone.
        if (bus_data_ok) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (if_flush) begin
          drop_d  = 1'b1;
        end
      end
      D_REQ: begin
        if (bus_addr_ok) begin
          state_d   = D_WAIT;
          bus_req_d = 1'b0;
        end
      end
      D_WAIT: begin
        if (bus_data_ok) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    i_done_d = i_done_q;
    i_buf_d  = i_buf_q;
    d_done_d = d_done_q;
    d_buf_d  = d_buf_q;
    if (i_cmpl && if_stall && !if_flush) begin
      i_done_d = 1'b1;
      i_buf_d  = bus_rdata;
    end else if (!if_stall || if_flush) begin
      i_done_d = 1'b0;
    end
    if (d_cmpl && mem_stall) begin
      d_done_d = 1'b1;
      d_buf_d  = bus_rdata;
    end else if (!mem_stall) begin
      d_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wstrb_q <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      drop_q      <= 1'b0;
      i_buf_q     <= 32'h0;
      d_buf_q     <= 32'h0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      drop_q      <= drop_d;
      i_buf_q     <= i_buf_d;
      d_buf_q     <= d_buf_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign i_rdata    = i_cmpl ? bus_rdata : i_buf_q;
  assign d_rdata    = d_cmpl ? bus_rdata : d_buf_q;
  assign i_stallreq = i_en & ~i_done_q & ~i_cmpl;
  assign d_stallreq = d_en & ~d_done_q & ~d_cmpl;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected bus transactions are queued by
// the stimulus and checked by a monitor whenever the bus accepts an address.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_en, if_stall, if_flush, d_en, mem_stall;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_wen;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic        i_stallreq, d_stallreq, bus_req, bus_wr;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_stallreq(i_stallreq),
    .if_stall(if_stall), .if_flush(if_flush),
    .d_en(d_en), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stallreq(d_stallreq), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    exp_q.push_back('{wr: wr, strb: strb, addr: addr, wdata: wdata});
  endtask

  // Drive the bus response for the current cycle, then wait to the sampling point.
  task automatic cyc(input logic aok, input logic dok, input logic [31:0] rd);
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  // Scoreboard monitor: every accepted address must match the next expected transaction.
  always @(negedge clk) begin
    if (resetn && bus_req && bus_addr_ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected actual addr=0x%08h required=no transaction", bus_addr);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_wr", {31'b0, bus_wr}, {31'b0, e.wr});
        chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, e.strb});
        if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    i_en = 1'b0; d_en = 1'b0; if_stall = 1'b0; if_flush = 1'b0; mem_stall = 1'b0;
    d_wen = 4'h0; i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    // Reset values; stall request follows en while in reset
    do_reset();
    resetn = 1'b0;
    i_en = 1'b1;
    @(negedge clk);
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_wr", {31'b0, bus_wr}, 32'h0);
    chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_i_stallreq", {31'b0, i_stallreq}, 32'h1);
    chk("rst_d_stallreq", {31'b0, d_stallreq}, 32'h0);
    do_reset();

    // Single fetch, minimum latency
    i_en = 1'b1; i_addr = 32'hBFC00000;
    push_exp(1'b0, 4'h0, 32'hBFC00000, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("f1_c0_stallreq", {31'b0, i_stallreq}, 32'h1);
    chk("f1_c0_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    cyc(1'b1, 1'b0, 32'h0);
    chk("f1_c1_stallreq", {31'b0, i_stallreq}, 32'h1);
    chk("f1_c1_bus_req", {31'b0, bus_req}, 32'h1);
    nxt();
    cyc(1'b0, 1'b1, 32'h24080001);
    chk("f1_c2_stallreq", {31'b0, i_stallreq}, 32'h0);
    chk("f1_c2_rdata", i_rdata, 32'h24080001);
    chk("f1_c2_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    i_en = 1'b0;
    // Stray data_ok in IDLE is ignored
    cyc(1'b0, 1'b1, 32'hBAD0BAD0);
    chk("stray_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    cyc(1'b0, 1'b0, 32'h0);
    chk("stray_after_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();

    // Fetch completes while IF stalled for 3 cycles
    i_en = 1'b1; i_addr = 32'hBFC00008;
    push_exp(1'b0, 4'h0, 32'hBFC00008, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    if_stall = 1'b1;
    cyc(1'b0, 1'b1, 32'h11111111);
    chk("st_c2_rdata", i_rdata, 32'h11111111);
    chk("st_c2_stallreq", {31'b0, i_stallreq}, 32'h0);
    nxt();
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("st_hold_rdata", i_rdata, 32'h11111111);
      chk("st_hold_stallreq", {31'b0, i_stallreq}, 32'h0);
      chk("st_hold_no_reissue", {31'b0, bus_req}, 32'h0);
      nxt();
    end
    if_stall = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("st_release_rdata", i_rdata, 32'h11111111);
    chk("st_release_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    i_addr = 32'hBFC0000C;
    push_exp(1'b0, 4'h0, 32'hBFC0000C, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("st_done_cleared_stallreq", {31'b0, i_stallreq}, 32'h1);
    nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    cyc(1'b0, 1'b1, 32'h33333333);
    chk("st_next_rdata", i_rdata, 32'h33333333);
    nxt();
    i_en = 1'b0;

    // Flush while waiting for data: the returning word is dropped
    i_en = 1'b1; i_addr = 32'hBFC00010;
    push_exp(1'b0, 4'h0, 32'hBFC00010, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    if_flush = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    chk("fl_wait_stallreq", {31'b0, i_stallreq}, 32'h1);
    nxt();
    if_flush = 1'b0; i_addr = 32'h80000100;
    cyc(1'b0, 1'b1, 32'h22222222);
    chk("fl_drop_rdata", i_rdata, 32'h11111111);
    chk("fl_drop_stallreq", {31'b0, i_stallreq}, 32'h1);
    nxt();
    push_exp(1'b0, 4'h0, 32'h80000100, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("fl_idle_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    cyc(1'b1, 1'b0, 32'h0);
    chk("fl_reissue_bus_req", {31'b0, bus_req}, 32'h1);
    nxt();
    cyc(1'b0, 1'b1, 32'h44444444);
    chk("fl_new_rdata", i_rdata, 32'h44444444);
    chk("fl_new_stallreq", {31'b0, i_stallreq}, 32'h0);
    nxt();
    i_en = 1'b0;

    // Reset during D_WAIT with IF holding a buffered result
    i_en = 1'b1; i_addr = 32'hBFC00020;
    push_exp(1'b0, 4'h0, 32'hBFC00020, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    if_stall = 1'b1; d_en = 1'b1; d_wen = 4'h0; d_addr = 32'h80000020;
    cyc(1'b0, 1'b1, 32'h55555555); nxt();
    push_exp(1'b0, 4'h0, 32'h80000020, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rs_idone_stallreq", {31'b0, i_stallreq}, 32'h0);
    chk("rs_buf_rdata", i_rdata, 32'h55555555);
    nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    resetn = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("rs_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rs_i_stallreq", {31'b0, i_stallreq}, 32'h1);
    chk("rs_d_stallreq", {31'b0, d_stallreq}, 32'h1);
    chk("rs_i_buf_cleared", i_rdata, 32'h0);
    nxt();
    resetn = 1'b1; i_en = 1'b0; if_stall = 1'b0;
    push_exp(1'b0, 4'h0, 32'h80000020, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rs_idle_bus_req", {31'b0, bus_req}, 32'h0);
    nxt();
    cyc(1'b1, 1'b0, 32'h0);
    chk("rs_reissue_bus_req", {31'b0, bus_req}, 32'h1);
    nxt();
    cyc(1'b0, 1'b1, 32'h66666666);
    chk("rs_load_rdata", d_rdata, 32'h66666666);
    chk("rs_load_stallreq", {31'b0, d_stallreq}, 32'h0);
    nxt();
    d_en = 1'b0;

    // Simultaneous fetch and store straight after reset
    do_reset();
    i_en = 1'b1; i_addr = 32'hBFC00004;
    d_en = 1'b1; d_wen = 4'hF; d_addr = 32'h80000010; d_wdata = 32'hDEADBEEF;
`ifdef MEM_ARB_RR_EN
    push_exp(1'b0, 4'h0, 32'hBFC00004, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0);
    chk("sim_first_wr", {31'b0, bus_wr}, 32'h0);
    nxt();
    cyc(1'b0, 1'b1, 32'h12345678);
    chk("sim_fetch_rdata", i_rdata, 32'h12345678);
    chk("sim_d_waiting", {31'b0, d_stallreq}, 32'h1);
    nxt();
    i_en = 1'b0;
    push_exp(1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    cyc(1'b0, 1'b1, 32'h0);
    chk("sim_store_done", {31'b0, d_stallreq}, 32'h0);
    nxt();
    d_en = 1'b0;
`else
    push_exp(1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0);
    chk("sim_first_wr", {31'b0, bus_wr}, 32'h1);
    nxt();
    cyc(1'b0, 1'b1, 32'h0);
    chk("sim_store_done", {31'b0, d_stallreq}, 32'h0);
    chk("sim_i_waiting", {31'b0, i_stallreq}, 32'h1);
    nxt();
    d_en = 1'b0;
    push_exp(1'b0, 4'h0, 32'hBFC00004, 32'h0);
    cyc(1'b0, 1'b0, 32'h0); nxt();
    cyc(1'b1, 1'b0, 32'h0); nxt();
    cyc(1'b0, 1'b1, 32'h12345678);
    chk("sim_fetch_rdata", i_rdata, 32'h12345678);
    nxt();
    i_en = 1'b0;
`endif
    repeat (3) begin
      cyc(1'b0, 1'b0, 32'h0);
      nxt();
    end
    chk("bus_queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
